axil_ctrl_slave: RTL and testbench

AXIL_CTRL_SLAVE -- requirements
Module: axil_ctrl_slave

---
 rtl/axil_ctrl_pkg.sv | 32 +++
 rtl/axil_reg_bank.sv | 53 +++++
 rtl/axil_ctrl_slave.sv | 197 +++++++++++++++++++
 tb/tb_axil_ctrl_slave.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_ctrl_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge helper for the AXI4-Lite control slave.
package axil_ctrl_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned CTRL_IDX   = 32'd0;
  localparam int unsigned STATUS_IDX = 32'd1;
  localparam int unsigned FIRST_USER = 32'd2;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// USER register storage: byte-strobed writes and a combinational read port returning the current value.
module axil_reg_bank
  import axil_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_W-3:0]            wr_idx,
  input  logic [31:0]                  wr_data,
  input  logic [3:0]                   wr_strb,
  input  logic [ADDR_W-3:0]            rd_idx,
  output logic [31:0]                  rd_data,
  output logic [32*(NUM_REGS-2)-1:0]   user_o
);

  localparam int unsigned NUM_USER = 32'(NUM_REGS - 2);

  logic [31:0] user_r [NUM_USER];
  logic [31:0] rd_data_s;

  // USER registers: cleared by reset, byte-merged on a qualified write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_USER; i++) begin
        user_r[i] <= 32'h0000_0000;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_USER; i++) begin
        if (wr_en && (32'(wr_idx) == (i + FIRST_USER))) begin
          user_r[i] <= strb_merge(user_r[i], wr_data, wr_strb);
        end
      end
    end
  end

  // Read mux: OR of the one register whose index matches (0 for no match).
  always_comb begin
    rd_data_s = 32'h0000_0000;
    for (int unsigned i = 0; i < NUM_USER; i++) begin
      rd_data_s = rd_data_s | ({32{32'(rd_idx) == (i + FIRST_USER)}} & user_r[i]);
    end
  end

  assign rd_data = rd_data_s;

  for (genvar g = 0; g < NUM_REGS - 2; g++) begin : g_user_out
    assign user_o[32*g +: 32] = user_r[g];
  end

endmodule

// File: rtl/axil_ctrl_slave.sv
// AXI4-Lite control slave: CTRL start pulse, live STATUS, and a bank of USER registers.
module axil_ctrl_slave
  import axil_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           s_awaddr,
  input  logic                        s_awvalid,
  output logic                        s_awready,
  input  logic [31:0]                 s_wdata,
  input  logic [3:0]                  s_wstrb,
  input  logic                        s_wvalid,
  output logic                        s_wready,
  output logic [1:0]                  s_bresp,
  output logic                        s_bvalid,
  input  logic                        s_bready,
  input  logic [ADDR_W-1:0]           s_araddr,
  input  logic                        s_arvalid,
  output logic                        s_arready,
  output logic [31:0]                 s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        s_rvalid,
  input  logic                        s_rready,
  output logic                        start_o,
  input  logic [31:0]                 status_i,
  output logic [32*(NUM_REGS-2)-1:0]  user_o
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

  wr_state_t wr_state_r, wr_state_next_s;
  rd_state_t rd_state_r, rd_state_next_s;

  logic             ready_en_r;
  logic             aw_held_r, w_held_r;
  logic [IDX_W-1:0] aw_idx_r;
  logic [31:0]      wdata_r;
  logic [3:0]       wstrb_r;
  logic [1:0]       bresp_r, rresp_r;
  logic [31:0]      rdata_r;
  logic             start_r;

  logic             aw_hs_s, w_hs_s, ar_hs_s, commit_s, cmt_valid_s, bank_wr_en_s;
  logic [IDX_W-1:0] cmt_idx_s, ar_idx_s;
  logic [31:0]      cmt_data_s, bank_rd_data_s, rd_word_s;
  logic [3:0]       cmt_strb_s;
  logic [1:0]       rd_resp_s;
  logic             unused_s;

  assign unused_s = ^{s_awaddr[1:0], s_araddr[1:0]};

  // Ready gating: keeps every ready low during reset and raises it on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en_r <= 1'b0;
    else      ready_en_r <= 1'b1;
  end

  assign s_awready = ready_en_r && !aw_held_r && (wr_state_r == W_IDLE);
  assign s_wready  = ready_en_r && !w_held_r  && (wr_state_r == W_IDLE);
  assign s_arready = ready_en_r && (rd_state_r == R_IDLE);
  assign s_bvalid  = (wr_state_r == W_RESP);
  assign s_rvalid  = (rd_state_r == R_DATA);

  assign aw_hs_s = s_awvalid && s_awready;
  assign w_hs_s  = s_wvalid && s_wready;
  assign ar_hs_s = s_arvalid && s_arready;

  // A channel counts as held if latched earlier or handshaking on this very edge.
  assign cmt_idx_s  = aw_held_r ? aw_idx_r : s_awaddr[ADDR_W-1:2];
  assign cmt_data_s = w_held_r  ? wdata_r  : s_wdata;
  assign cmt_strb_s = w_held_r  ? wstrb_r  : s_wstrb;
  assign commit_s   = (wr_state_r == W_IDLE) && (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);

  assign cmt_valid_s  = (32'(cmt_idx_s) < NUM_REGS_U);
  assign bank_wr_en_s = commit_s && cmt_valid_s && (32'(cmt_idx_s) >= FIRST_USER);
  assign ar_idx_s     = s_araddr[ADDR_W-1:2];

  axil_reg_bank #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bank_wr_en_s),
    .wr_idx  (cmt_idx_s),
    .wr_data (cmt_data_s),
    .wr_strb (cmt_strb_s),
    .rd_idx  (ar_idx_s),
    .rd_data (bank_rd_data_s),
    .user_o  (user_o)
  );

  // Write FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_state_r <= W_IDLE;
    else      wr_state_r <= wr_state_next_s;
  end

  // Write FSM next state: commit moves to RESP, B handshake returns to IDLE.
  always_comb begin
    wr_state_next_s = wr_state_r;
    case (wr_state_r)
      W_IDLE:  if (commit_s) wr_state_next_s = W_RESP; else wr_state_next_s = W_IDLE;
      W_RESP:  if (s_bready) wr_state_next_s = W_IDLE; else wr_state_next_s = W_RESP;
      default: wr_state_next_s = W_IDLE;
    endcase
  end

  // AW/W latches: capture each channel independently, release both on commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      aw_idx_r  <= '0;
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'h0;
    end else if (commit_s) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_held_r <= 1'b1;
        aw_idx_r  <= s_awaddr[ADDR_W-1:2];
      end
      if (w_hs_s) begin
        w_held_r <= 1'b1;
        wdata_r  <= s_wdata;
        wstrb_r  <= s_wstrb;
      end
    end
  end

  // Write response and start pulse, both decided on the commit edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bresp_r <= RESP_OKAY;
      start_r <= 1'b0;
    end else begin
      if (commit_s) bresp_r <= cmt_valid_s ? RESP_OKAY : RESP_SLVERR;
      start_r <= commit_s && (32'(cmt_idx_s) == CTRL_IDX) && cmt_strb_s[0] && cmt_data_s[0];
    end
  end

  assign s_bresp = bresp_r;
  assign start_o = start_r;

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_state_r <= R_IDLE;
    else      rd_state_r <= rd_state_next_s;
  end

  // Read FSM next state: AR handshake enters DATA, R handshake returns to IDLE.
  always_comb begin
    rd_state_next_s = rd_state_r;
    case (rd_state_r)
      R_IDLE:  if (ar_hs_s)  rd_state_next_s = R_DATA; else rd_state_next_s = R_IDLE;
      R_DATA:  if (s_rready) rd_state_next_s = R_IDLE; else rd_state_next_s = R_DATA;
      default: rd_state_next_s = R_IDLE;
    endcase
  end

  // Read data mux: CTRL reads 0, STATUS is live, out-of-range is SLVERR with 0.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    rd_resp_s = RESP_OKAY;
    if (32'(ar_idx_s) >= NUM_REGS_U) begin
      rd_resp_s = RESP_SLVERR;
      rd_word_s = 32'h0000_0000;
    end else if (32'(ar_idx_s) == STATUS_IDX) begin
      rd_word_s = status_i;
    end else if (32'(ar_idx_s) == CTRL_IDX) begin
      rd_word_s = 32'h0000_0000;
    end else begin
      rd_word_s = bank_rd_data_s;
    end
  end

  // Read data register: captured on the AR handshake, held while RVALID is up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r <= 32'h0000_0000;
      rresp_r <= RESP_OKAY;
    end else if (ar_hs_s) begin
      rdata_r <= rd_word_s;
      rresp_r <= rd_resp_s;
    end
  end

  assign s_rdata = rdata_r;
  assign s_rresp = rresp_r;

endmodule

// File: tb/tb_axil_ctrl_slave.sv
// Directed self-checking bench for axil_ctrl_slave (ADDR_W=6, NUM_REGS=8).
module tb_axil_ctrl_slave;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   s_awaddr;
  logic         s_awvalid, s_awready;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic         s_wvalid, s_wready;
  logic [1:0]   s_bresp;
  logic         s_bvalid, s_bready;
  logic [5:0]   s_araddr;
  logic         s_arvalid, s_arready;
  logic [31:0]  s_rdata;
  logic [1:0]   s_rresp;
  logic         s_rvalid, s_rready;
  logic         start_o;
  logic [31:0]  status_i;
  logic [191:0] user_o;

  int errors = 0;
  int checks = 0;

  logic [1:0]  resp;
  logic [31:0] rd;

  always #5 clk = ~clk;

  axil_ctrl_slave #(.ADDR_W(6), .NUM_REGS(8)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .start_o(start_o), .status_i(status_i), .user_o(user_o)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full write with AW and W presented together; called and returns at posedge+1.
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] r);
    int n;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(s_awready && s_wready) && n < 20) begin @(negedge clk); n++; end
    chk("wr_ready_wait", 192'(n < 20), 192'(1));
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
    chk("bvalid_wait", 192'(n < 20), 192'(1));
    r = s_bresp;
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  // Full read; called and returns at posedge+1.
  task automatic axi_read(input logic [5:0] addr, output logic [31:0] d, output logic [1:0] r);
    int n;
    s_araddr = addr; s_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_arready && n < 20) begin @(negedge clk); n++; end
    chk("ar_ready_wait", 192'(n < 20), 192'(1));
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rvalid_wait", 192'(n < 20), 192'(1));
    d = s_rdata; r = s_rresp;
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    s_awaddr = 6'h00; s_awvalid = 1'b0; s_wdata = 32'h0; s_wstrb = 4'h0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = 6'h00; s_arvalid = 1'b0; s_rready = 1'b0;
    status_i = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_readies", {s_awready, s_wready, s_arready}, 3'b000);
    chk("rst_valids",  {s_bvalid, s_rvalid, start_o}, 3'b000);
    chk("rst_resp",    {s_bresp, s_rresp}, 4'h0);
    chk("rst_rdata",   s_rdata, 32'h0);
    chk("rst_user",    user_o, 192'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_readies", {s_awready, s_wready, s_arready}, 3'b111);
    @(posedge clk); #1;

    // AW at cycle 0, W at cycle 3, to 0x08
    s_awaddr = 6'h08; s_awvalid = 1'b1;
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    @(negedge clk);
    chk("aw_latched_awready", {s_awready, s_wready, s_bvalid}, 3'b010);
    @(posedge clk); #1;
    @(negedge clk);
    chk("aw_only_c1_bvalid", s_bvalid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("aw_only_c2_bvalid", s_bvalid, 1'b0);
    @(posedge clk); #1;
    s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    @(negedge clk);
    chk("split_bvalid", s_bvalid, 1'b1);
    chk("split_bresp",  s_bresp, 2'b00);
    chk("split_user2",  user_o[31:0], 32'hDEADBEEF);
    chk("split_awready_in_resp", s_awready, 1'b0);
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    @(negedge clk);
    chk("split_after_b", {s_bvalid, s_awready, s_wready}, 3'b011);
    @(posedge clk); #1;

    // Byte strobes
    axi_write(6'h0C, 32'h11223344, 4'h5, resp);
    chk("strb_bresp", resp, 2'b00);
    axi_read(6'h0C, rd, resp);
    chk("strb_rdata", rd, 32'h00220044);
    chk("strb_rresp", resp, 2'b00);
    chk("strb_user3", user_o[63:32], 32'h00220044);

    // CTRL start pulse
    s_awaddr = 6'h00; s_wdata = 32'h1; s_wstrb = 4'h1; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    chk("start_before", start_o, 1'b0);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    chk("start_pulse", start_o, 1'b1);
    chk("ctrl_bresp", {s_bvalid, s_bresp}, 3'b100);
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    @(negedge clk);
    chk("start_after", start_o, 1'b0);
    @(posedge clk); #1;
    axi_read(6'h00, rd, resp);
    chk("ctrl_read", {rd, resp}, {32'h0, 2'b00});

    // Low address bits ignored
    axi_read(6'h0B, rd, resp);
    chk("addr_lowbits", {rd, resp}, {32'hDEADBEEF, 2'b00});

    // STATUS sampled at the AR handshake edge, write ignored with OKAY
    status_i = 32'hCAFE0001;
    s_araddr = 6'h04; s_arvalid = 1'b1;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    status_i = 32'h0BAD0BAD;
    @(negedge clk);
    chk("status_rdata", {s_rvalid, s_rdata, s_rresp}, {1'b1, 32'hCAFE0001, 2'b00});
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
    axi_write(6'h04, 32'hFFFFFFFF, 4'hF, resp);
    chk("status_wr_bresp", resp, 2'b00);
    chk("status_wr_user", user_o, {128'h0, 32'h00220044, 32'hDEADBEEF});

    // Out-of-range index
    axi_read(6'h3C, rd, resp);
    chk("oor_read", {rd, resp}, {32'h0, 2'b10});
    axi_write(6'h3C, 32'hFFFFFFFF, 4'hF, resp);
    chk("oor_bresp", resp, 2'b10);
    chk("oor_user", user_o, {128'h0, 32'h00220044, 32'hDEADBEEF});

    // bready held low: bvalid stays, second AW blocked until B handshake
    s_awaddr = 6'h10; s_wdata = 32'hA5A5A5A5; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    s_awaddr = 6'h14;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bvalid_awready", {s_bvalid, s_awready}, 2'b10);
      @(posedge clk); #1;
    end
    chk("bp_user4", user_o[95:64], 32'hA5A5A5A5);
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    @(negedge clk);
    chk("bp_after_b", {s_bvalid, s_awready}, 2'b01);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    @(negedge clk);
    chk("bp_second_aw_taken", {s_awready, s_bvalid}, 2'b00);
    s_wdata = 32'h5A5A5A5A; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    @(negedge clk);
    chk("bp_second_b", {s_bvalid, s_bresp}, 3'b100);
    chk("bp_user5", user_o[127:96], 32'h5A5A5A5A);
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;

    // Same-edge read and write to 0x0C: read sees the old value
    s_araddr = 6'h0C; s_arvalid = 1'b1;
    s_awaddr = 6'h0C; s_wdata = 32'h77777777; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(posedge clk); #1;
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    chk("rw_same_edge_rdata", {s_rvalid, s_rdata}, {1'b1, 32'h00220044});
    chk("rw_same_edge_bvalid", s_bvalid, 1'b1);
    s_rready = 1'b1; s_bready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0; s_bready = 1'b0;
    axi_read(6'h0C, rd, resp);
    chk("rw_new_value", rd, 32'h77777777);

    // Reset while rvalid=1 with an AW latched
    s_araddr = 6'h08; s_arvalid = 1'b1; s_awaddr = 6'h10; s_awvalid = 1'b1;
    @(posedge clk); #1;
    s_arvalid = 1'b0; s_awvalid = 1'b0;
    @(negedge clk);
    chk("prerst_rvalid", {s_rvalid, s_rdata, s_awready}, {1'b1, 32'hDEADBEEF, 1'b0});
    #2 rst = 1'b0;
    #1;
    chk("midrst_outputs", {s_rvalid, s_rdata, s_awready, s_arready}, {1'b0, 32'h0, 2'b00});
    chk("midrst_user", user_o, 192'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst_state", {s_awready, s_wready, s_rvalid, s_bvalid}, 4'b1100);
    @(posedge clk); #1;
    s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_no_b", {s_bvalid, s_wready}, 2'b00);
      @(posedge clk); #1;
    end
    axi_read(6'h08, rd, resp);
    chk("postrst_read08", {rd, resp}, {32'h0, 2'b00});
    chk("postrst_user", user_o, 192'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
